// File: rtl/hazard_controller.sv
// hazard_controller
//
// Decode-stage hazard sequencer for a five-stage pipeline. It classifies the
// register usage of the instruction in IF/ID and tracks the destination and
// load flag of the instruction in EX. From these it drives the PC, IF/ID and
// ID/EX enables to:
//   - stall for load-use hazards,
//   - flush after taken branches and jumps,
//   - freeze while data memory is busy.
//
// Optional feature: define HAZARD_PERF_EN to add saturating performance
// counters. These count stall, flush and memory-wait cycles and are exposed
// as three extra ports. The default build omits the counters; control
// behaviour is identical in both builds.
//
// Ports:
//   clk              pipeline clock, rising edge
//   reset_n          synchronous active-low reset
//   id_instr[31:0]   instruction held in IF/ID
//   id_valid         IF/ID holds a real instruction
//   ex_branch_taken  EX resolved a taken branch/jal/jalr this cycle
//   mem_busy         data memory not ready; the whole pipeline freezes
//   pc_write         PC register enable
//   ifid_write       IF/ID register enable
//   ifid_flush       load NOP into IF/ID
//   idex_bubble      load NOP into ID/EX
//   hazard_state     previous cycle's decision: RUN=0 LU_STALL=1 FLUSH=2 MEM_WAIT=3
//   stall_cycles, flush_count, mem_wait_cycles [CNT_W-1:0]  (HAZARD_PERF_EN only)

module hazard_controller
`ifdef HAZARD_PERF_EN
  #(
    parameter int unsigned CNT_W = 16
  )
`endif
  (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  hazard_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mem_wait_cycles
`endif
  );

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StFlush   = 2'd2,
    StMemWait = 2'd3
  } state_e;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  state_e     state_q, state_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       ex_load_q, ex_load_d;
  logic       pending_flush_q, pending_flush_d;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       rs1_used, rs2_used;
  logic       load_use;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];

  // funct3/funct7 do not affect register usage.
  logic unused_bits;
  assign unused_bits = ^{id_instr[31:25], id_instr[14:12]};

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      OpReg, OpStore, OpBranch: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OpImm, OpLoad, OpJalr: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign load_use = ex_load_q && (ex_rd_q != 5'd0) && id_valid &&
                    ((rs1_used && (rs1 == ex_rd_q)) || (rs2_used && (rs2 == ex_rd_q)));

  // Priority decision: reset, freeze, flush, load-use stall, normal issue.
  always_comb begin
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    idex_bubble     = 1'b0;
    state_d         = StRun;
    ex_rd_d         = id_valid ? rd : 5'd0;
    ex_load_d       = id_valid && (opcode == OpLoad);
    pending_flush_d = pending_flush_q;

    if (!reset_n) begin
      pc_write        = 1'b0;
      ifid_write      = 1'b0;
      ifid_flush      = 1'b1;
      idex_bubble     = 1'b1;
      ex_rd_d         = 5'd0;
      ex_load_d       = 1'b0;
      pending_flush_d = 1'b0;
    end else if (mem_busy) begin
      pc_write        = 1'b0;
      ifid_write      = 1'b0;
      state_d         = StMemWait;
      ex_rd_d         = ex_rd_q;
      ex_load_d       = ex_load_q;
      // Remember a branch resolved while frozen so the flush still happens.
      pending_flush_d = pending_flush_q || ex_branch_taken;
    end else if (ex_branch_taken || pending_flush_q) begin
      // Any load-use on the wrong-path IF/ID instruction is discarded here.
      ifid_flush      = 1'b1;
      idex_bubble     = 1'b1;
      state_d         = StFlush;
      ex_rd_d         = 5'd0;
      ex_load_d       = 1'b0;
      pending_flush_d = 1'b0;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = StLuStall;
      // The bubble leaves EX empty, so next cycle's load_use is 0.
      ex_rd_d     = 5'd0;
      ex_load_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= StRun;
      ex_rd_q         <= 5'd0;
      ex_load_q       <= 1'b0;
      pending_flush_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ex_rd_q         <= ex_rd_d;
      ex_load_q       <= ex_load_d;
      pending_flush_q <= pending_flush_d;
    end
  end

  assign hazard_state = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q, mem_wait_q;

  // state_d doubles as the decision code for the current cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q    <= '0;
      flush_q    <= '0;
      mem_wait_q <= '0;
    end else begin
      if ((state_d == StLuStall) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if ((state_d == StFlush) && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
      if ((state_d == StMemWait) && (mem_wait_q != '1)) begin
        mem_wait_q <= mem_wait_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles    = stall_q;
  assign flush_count     = flush_q;
  assign mem_wait_cycles = mem_wait_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller. The driver applies one directed
// vector per cycle just after the rising edge and queues the expected
// controls and state. The monitor pops the queue and compares on each
// falling edge.

module tb_hazard_controller;

  localparam logic [31:0] Lw5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] Add6  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] Lw0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] AddX0 = 32'h00200333; // add  x6,x0,x2
  localparam logic [31:0] Lui5  = 32'h000012B7; // lui  x5,1

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        ex_branch_taken;
  logic        mem_busy;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  hazard_state;

  typedef struct {
    logic [3:0] ctl;   // {pc_write, ifid_write, ifid_flush, idex_bubble}
    logic [1:0] st;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
  logic [1:0] stall_cycles, flush_count, mem_wait_cycles;

  hazard_controller #(
    .CNT_W(2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_instr       (id_instr),
    .id_valid       (id_valid),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy       (mem_busy),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .hazard_state   (hazard_state),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count),
    .mem_wait_cycles(mem_wait_cycles)
  );

  task automatic check_cnt(input string name, input logic [1:0] got, input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask
`else
  hazard_controller dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_instr       (id_instr),
    .id_valid       (id_valid),
    .ex_branch_taken(ex_branch_taken),
    .mem_busy       (mem_busy),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .hazard_state   (hazard_state)
  );
`endif

  // One vector per cycle; st is the decision taken in the previous cycle.
  task automatic step(input string name, input logic rst_n, input logic [31:0] instr,
                      input logic valid, input logic br, input logic busy,
                      input logic [3:0] ctl, input logic [1:0] st);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n         = rst_n;
    id_instr        = instr;
    id_valid        = valid;
    ex_branch_taken = br;
    mem_busy        = busy;
    e.ctl  = ctl;
    e.st   = st;
    e.name = name;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] got;
      e   = exp_q.pop_front();
      got = {pc_write, ifid_write, ifid_flush, idex_bubble};
      checks++;
      if (got !== e.ctl || hazard_state !== e.st) begin
        errors++;
        $display("FAIL %s: got ctl=%b state=%0d, expected ctl=%b state=%0d",
                 e.name, got, hazard_state, e.ctl, e.st);
      end
    end
  end

  initial begin
    reset_n         = 1'b0;
    id_instr        = 32'h0000_0013;
    id_valid        = 1'b0;
    ex_branch_taken = 1'b0;
    mem_busy        = 1'b0;
    repeat (2) @(posedge clk);

    //    name              rst  instr  vld  br   busy  ctl      st
    step("reset",           0, Add6,  1, 1, 0, 4'b0011, 2'd0);
    step("lw5_issue",       1, Lw5,   1, 0, 0, 4'b1100, 2'd0);
    step("lu_stall",        1, Add6,  1, 0, 0, 4'b0001, 2'd0);
    step("lu_release",      1, Add6,  1, 0, 0, 4'b1100, 2'd1);
    step("lw0_issue",       1, Lw0,   1, 0, 0, 4'b1100, 2'd0);
    step("x0_no_stall",     1, AddX0, 1, 0, 0, 4'b1100, 2'd0);
    step("lw5_issue2",      1, Lw5,   1, 0, 0, 4'b1100, 2'd0);
    step("lui_no_stall",    1, Lui5,  1, 0, 0, 4'b1100, 2'd0);
    step("lw5_issue3",      1, Lw5,   1, 0, 0, 4'b1100, 2'd0);
    step("branch_flush",    1, Add6,  1, 1, 0, 4'b1111, 2'd0);
    step("after_flush",     1, Add6,  1, 0, 0, 4'b1100, 2'd2);
    step("lw5_issue4",      1, Lw5,   1, 0, 0, 4'b1100, 2'd0);
    step("freeze1",         1, Add6,  1, 0, 1, 4'b0000, 2'd0);
    step("freeze2_branch",  1, Add6,  1, 1, 1, 4'b0000, 2'd3);
    step("freeze3",         1, Add6,  1, 0, 1, 4'b0000, 2'd3);
    step("deferred_flush",  1, Add6,  1, 0, 0, 4'b1111, 2'd3);
    step("post_def_flush",  1, Add6,  1, 0, 0, 4'b1100, 2'd2);
    step("lw5_issue5",      1, Lw5,   1, 0, 0, 4'b1100, 2'd0);
`ifdef HAZARD_PERF_EN
    // Cycles counted so far: stall 1, flush 2, mem wait 3.
    check_cnt("stall_cycles_mid", stall_cycles, 2'd1);
    check_cnt("flush_count_mid", flush_count, 2'd2);
    check_cnt("mem_wait_cycles_mid", mem_wait_cycles, 2'd3);
`endif
    step("lu_stall2",       1, Add6,  1, 0, 0, 4'b0001, 2'd0);
    step("reset_in_stall",  0, Add6,  1, 0, 0, 4'b0011, 2'd1);
    step("after_reset",     1, Add6,  1, 0, 0, 4'b1100, 2'd0);

    for (int i = 0; i < 5; i++) begin
      step("sat_lw5",       1, Lw5,   1, 0, 0, 4'b1100, 2'd0);
      step("sat_stall",     1, Add6,  1, 0, 0, 4'b0001, 2'd0);
      step("sat_release",   1, Add6,  1, 0, 0, 4'b1100, 2'd1);
    end

    @(posedge clk);
    #1;
`ifdef HAZARD_PERF_EN
    check_cnt("stall_cycles_sat", stall_cycles, 2'd3);
    check_cnt("flush_count_after_reset", flush_count, 2'd0);
    check_cnt("mem_wait_after_reset", mem_wait_cycles, 2'd0);
`endif

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #6;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
